// File: rtl/sdram_model.sv
// sdram_model: chip-side SDRAM responder with init tracking, per-bank state, CL-timed reads and a first-violation latch.
// Optional refresh watchdog (error 8) is enabled by defining SDRAM_MODEL_REFWDOG_EN.
module sdram_model #(
    parameter int ROW_AW  = 4,
    parameter int COL_AW  = 6,
    parameter int DQ_W    = 16,
    parameter int T_RCD   = 2,
    parameter int T_RP    = 2,
    parameter int T_RFC   = 7,
    parameter int REF_MAX = 780
) (
    input  logic            clk_100m,
    input  logic            rst_n,
    input  logic            sdram_cke,
    input  logic            sdram_cs_n,
    input  logic            sdram_ras_n,
    input  logic            sdram_cas_n,
    input  logic            sdram_we_n,
    input  logic [1:0]      sdram_ba,
    input  logic [12:0]     sdram_addr,
    input  logic [1:0]      sdram_dqm,
    input  logic [DQ_W-1:0] dq_in,
    output logic [DQ_W-1:0] dq_out,
    output logic            dq_oe,
    output logic            init_ok,
    output logic            err,
    output logic [3:0]      err_code
);
    // state      | meaning
    // I_WAIT_PRE | waiting for PRECHARGE-all
    // I_REF1     | waiting for first AUTO REFRESH
    // I_REF2     | waiting for second AUTO REFRESH
    // I_WAIT_MRS | waiting for MRS
    // I_READY    | init done, init_ok=1
    localparam int AW = 2 + ROW_AW + COL_AW;
    localparam int HB = DQ_W / 2;
    localparam logic [3:0] RCD4 = 4'(T_RCD);
    localparam logic [3:0] RP4  = 4'(T_RP);
    localparam logic [3:0] RFC4 = 4'(T_RFC);

    typedef enum logic [2:0] {I_WAIT_PRE, I_REF1, I_REF2, I_WAIT_MRS, I_READY} init_t;
    init_t init_st;

    logic [DQ_W-1:0]   mem [0:(1<<AW)-1];
    logic [3:0]        mode_bl;
    logic              mode_cl2, mode_wb1;
    logic [3:0]        bank_open;
    logic [ROW_AW-1:0] bank_row [4];
    logic [3:0]        rcd_cnt [4];
    logic [3:0]        rp_cnt [4];
    logic [3:0]        rfc_cnt;

    logic              bst_act, bst_rd, bst_ap;
    logic [1:0]        bst_bank;
    logic [ROW_AW-1:0] bst_row;
    logic [COL_AW-1:0] bst_col;
    logic [3:0]        bst_len, bst_k;
    logic [1:0]        pipe_v;
    logic [DQ_W-1:0]   pipe_d [2];

    logic       cmd_ok, c_act, c_rd, c_wr, c_bst, c_pre, c_ref, c_mrs, c_any;
    logic [2:0] cmd;
    logic       unused_addr;
    assign cmd    = {sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign cmd_ok = !sdram_cs_n && sdram_cke;
    assign c_act  = cmd_ok && cmd == 3'b011;
    assign c_rd   = cmd_ok && cmd == 3'b101;
    assign c_wr   = cmd_ok && cmd == 3'b100;
    assign c_bst  = cmd_ok && cmd == 3'b110;
    assign c_pre  = cmd_ok && cmd == 3'b010;
    assign c_ref  = cmd_ok && cmd == 3'b001;
    assign c_mrs  = cmd_ok && cmd == 3'b000;
    assign c_any  = cmd_ok && cmd != 3'b111;
    assign unused_addr = ^sdram_addr;

    logic wd_hit;
`ifdef SDRAM_MODEL_REFWDOG_EN
    logic [15:0] wd_cnt;
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n)                wd_cnt <= '0;
        else if (!init_ok || c_ref) wd_cnt <= '0;
        else if (wd_cnt != 16'hFFFF) wd_cnt <= wd_cnt + 16'd1;
    end
    assign wd_hit = wd_cnt >= 16'(REF_MAX);
`else
    assign wd_hit = 1'b0;
`endif

    logic [3:0] cmd_viol, viol;
    logic       rp_busy;
    always_comb begin
        rp_busy = 1'b0;
        for (int b = 0; b < 4; b++) if (rp_cnt[b] < RP4) rp_busy = 1'b1;
        cmd_viol = 4'd0;
        if ((c_act || c_rd || c_wr) && !init_ok)                  cmd_viol = 4'd1;
        else if (c_any && rfc_cnt < RFC4)                         cmd_viol = 4'd6;
        else if ((c_rd || c_wr) && !bank_open[sdram_ba])          cmd_viol = 4'd2;
        else if ((c_rd || c_wr) && rcd_cnt[sdram_ba] < RCD4)      cmd_viol = 4'd4;
        else if (c_act && bank_open[sdram_ba])                    cmd_viol = 4'd3;
        else if (c_act && rp_cnt[sdram_ba] < RP4)                 cmd_viol = 4'd5;
        else if (c_ref && |bank_open)                             cmd_viol = 4'd7;
        else if (c_ref && rp_busy)                                cmd_viol = 4'd5;
        viol = (cmd_viol != 4'd0) ? cmd_viol : (wd_hit ? 4'd8 : 4'd0);
    end

    // One beat per edge: either beat 0 of a fresh command or the next beat of the running burst.
    logic              rw_go, burst_stop, beat_go, beat_rd, beat_ap, beat_last, pipe_kill;
    logic [1:0]        beat_bank;
    logic [ROW_AW-1:0] beat_row;
    logic [COL_AW-1:0] beat_base, beat_mask, beat_col;
    logic [3:0]        beat_k, beat_len, new_len;
    logic [AW-1:0]     beat_addr;
    assign rw_go      = (c_rd || c_wr) && cmd_viol == 4'd0;
    assign new_len    = (c_wr && mode_wb1) ? 4'd1 : mode_bl;
    assign burst_stop = bst_act && (c_bst || (c_pre && (sdram_addr[10] || sdram_ba == bst_bank)));
    assign beat_go    = rw_go || (bst_act && !burst_stop);
    assign pipe_kill  = (rw_go && c_wr) || (burst_stop && c_pre && bst_rd);

    always_comb begin
        beat_rd   = bst_rd;
        beat_ap   = bst_ap;
        beat_bank = bst_bank;
        beat_row  = bst_row;
        beat_base = bst_col;
        beat_k    = bst_k;
        beat_len  = bst_len;
        if (rw_go) begin
            beat_rd   = c_rd;
            beat_ap   = sdram_addr[10];
            beat_bank = sdram_ba;
            beat_row  = bank_row[sdram_ba];
            beat_base = sdram_addr[COL_AW-1:0];
            beat_k    = 4'd0;
            beat_len  = new_len;
        end
        beat_last = beat_k == beat_len - 4'd1;
        beat_mask = COL_AW'(beat_len - 4'd1);
        beat_col  = (beat_base & ~beat_mask) | ((beat_base + COL_AW'(beat_k)) & beat_mask);
        beat_addr = {beat_bank, beat_row, beat_col};
    end

    always_ff @(posedge clk_100m) begin
        if (beat_go && !beat_rd) begin
            if (!sdram_dqm[0]) mem[beat_addr][HB-1:0]    <= dq_in[HB-1:0];
            if (!sdram_dqm[1]) mem[beat_addr][DQ_W-1:HB] <= dq_in[DQ_W-1:HB];
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            bank_open <= '0;
            rfc_cnt   <= 4'hF;
            for (int b = 0; b < 4; b++) begin
                bank_row[b] <= '0;
                rcd_cnt[b]  <= 4'hF;
                rp_cnt[b]   <= 4'hF;
            end
        end else begin
            if (rfc_cnt != 4'hF) rfc_cnt <= rfc_cnt + 4'd1;
            for (int b = 0; b < 4; b++) begin
                if (rcd_cnt[b] != 4'hF) rcd_cnt[b] <= rcd_cnt[b] + 4'd1;
                if (rp_cnt[b] != 4'hF)  rp_cnt[b]  <= rp_cnt[b] + 4'd1;
            end
            if (beat_go && beat_last && beat_ap) begin
                bank_open[beat_bank] <= 1'b0;
                rp_cnt[beat_bank]    <= 4'd1;
            end
            if (c_act) begin
                bank_open[sdram_ba] <= 1'b1;
                bank_row[sdram_ba]  <= sdram_addr[ROW_AW-1:0];
                rcd_cnt[sdram_ba]   <= 4'd1;
            end
            if (c_pre) begin
                for (int b = 0; b < 4; b++) begin
                    if (sdram_addr[10] || sdram_ba == 2'(b)) begin
                        bank_open[b] <= 1'b0;
                        rp_cnt[b]    <= 4'd1;
                    end
                end
            end
            if (c_ref) rfc_cnt <= 4'd1;
        end
    end

    // Read beats enter a two-stage pipe; CL selects the tap that feeds the output register.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            bst_act   <= 1'b0;
            bst_rd    <= 1'b0;
            bst_ap    <= 1'b0;
            bst_bank  <= '0;
            bst_row   <= '0;
            bst_col   <= '0;
            bst_len   <= 4'd1;
            bst_k     <= '0;
            pipe_v    <= '0;
            pipe_d[0] <= '0;
            pipe_d[1] <= '0;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
        end else begin
            if (rw_go) begin
                bst_act  <= new_len != 4'd1;
                bst_rd   <= c_rd;
                bst_ap   <= sdram_addr[10];
                bst_bank <= sdram_ba;
                bst_row  <= bank_row[sdram_ba];
                bst_col  <= sdram_addr[COL_AW-1:0];
                bst_len  <= new_len;
                bst_k    <= 4'd1;
            end else if (burst_stop) begin
                bst_act <= 1'b0;
            end else if (bst_act) begin
                if (beat_last) bst_act <= 1'b0;
                else           bst_k   <= bst_k + 4'd1;
            end
            if (pipe_kill) begin
                pipe_v <= '0;
                dq_oe  <= 1'b0;
                dq_out <= '0;
            end else begin
                pipe_v    <= {pipe_v[0], beat_go && beat_rd};
                pipe_d[0] <= mem[beat_addr];
                pipe_d[1] <= pipe_d[0];
                dq_oe     <= mode_cl2 ? pipe_v[0] : pipe_v[1];
                dq_out    <= mode_cl2 ? (pipe_v[0] ? pipe_d[0] : '0) : (pipe_v[1] ? pipe_d[1] : '0);
            end
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            init_st  <= I_WAIT_PRE;
            init_ok  <= 1'b0;
            mode_bl  <= 4'd1;
            mode_cl2 <= 1'b0;
            mode_wb1 <= 1'b0;
            err      <= 1'b0;
            err_code <= 4'd0;
        end else begin
            if (c_mrs) begin
                case (sdram_addr[2:0])
                    3'd1:    mode_bl <= 4'd2;
                    3'd2:    mode_bl <= 4'd4;
                    3'd3:    mode_bl <= 4'd8;
                    default: mode_bl <= 4'd1;
                endcase
                mode_cl2 <= sdram_addr[6:4] == 3'd2;
                mode_wb1 <= sdram_addr[9];
            end
            case (init_st)
                I_WAIT_PRE: if (c_pre && sdram_addr[10]) init_st <= I_REF1;
                I_REF1:     if (c_ref) init_st <= I_REF2;
                I_REF2:     if (c_ref) init_st <= I_WAIT_MRS;
                I_WAIT_MRS: if (c_mrs) begin
                    init_st <= I_READY;
                    init_ok <= 1'b1;
                end
                default: ;
            endcase
            if (!err && viol != 4'd0) begin
                err      <= 1'b1;
                err_code <= viol;
            end
        end
    end
endmodule

// File: doc/sdram_model.md
# sdram_model

Synthesizable SDRAM device responder: the chip-side end of the SDRAM command bus driven by the SDRAM controller. It decodes CS/RAS/CAS/WE commands and tracks power-up init, the mode register and per-bank open rows. It serves reads and writes from a small on-chip array with CAS-latency-accurate data timing, and latches the first protocol or timing violation it sees. It replaces the external chip in simulation and in FPGA loopback builds.

## Interface
- ROW_AW, 4: row bits stored; upper row bits are ignored.
- COL_AW, 6: column bits stored.
- DQ_W, 16: data width; two DQM lanes, one per byte.
- T_RCD, 2: minimum cycles from ACTIVE to READ/WRITE on the same bank.
- T_RP, 2: minimum cycles from PRECHARGE to ACTIVE/REFRESH.
- T_RFC, 7: minimum cycles from AUTO REFRESH to any non-NOP command.
- REF_MAX, 780: refresh watchdog limit in cycles.
- clk_100m  in  1  device clock; all commands are sampled on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sdram_cke  in  1  clock enable; commands are ignored while low.
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  in  1 each  command.
- sdram_ba  in  2  bank address.
- sdram_addr  in  13  row, or column plus A10.
- sdram_dqm  in  2  write byte mask; ignored on reads.
- dq_in  in  DQ_W  write data.
- dq_out  out  DQ_W  read data.
- dq_oe  out  1  read-data drive enable.
- init_ok  out  1  init sequence completed.
- err  out  1  sticky violation flag.
- err_code  out  4  code of the first violation.

## Operation
- A command is valid when cs_n=0 and cke=1. {ras,cas,we} decode: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 110 BST, 010 PRECHARGE (A10=1 means all banks), 001 AUTO REFRESH, 000 MRS.
- Init FSM states:
  - I_WAIT_PRE: waits for PRECHARGE-all.
  - I_REF1, I_REF2: each waits for one AUTO REFRESH.
  - I_WAIT_MRS: waits for MRS.
  - I_READY: init_ok=1. Further MRS commands are still accepted and update the mode.
  - In any state before I_READY, NOP and other out-of-order commands leave the state unchanged.
- Mode register, set by MRS:
  - addr[2:0] is the burst length: 0→1, 1→2, 2→4, 3→8; other values→1.
  - addr[6:4] is the CAS latency: 2 or 3; other values→3.
  - addr[9]=1 makes writes single-beat.
  - Reset mode: BL=1, CL=3.
- Banks: four. Each has an open flag, a stored row, and cycle counters for tRCD/tRP.
- ACTIVE opens the addressed row. PRECHARGE closes the addressed bank, or all banks when A10=1.
- Array address is {ba, row[ROW_AW-1:0], col[COL_AW-1:0]}. Bursts are sequential and wrap within a BL-aligned block.
- WRITE: beat 0 is dq_in at the command edge; beats 1..BL-1 follow on the next edges. A byte whose DQM bit is high is not written.
- READ: beat k is on dq_out with dq_oe=1 during the cycle ending at edge T+CL+k, where T is the READ edge.
- Burst end:
  - A new READ/WRITE truncates the current burst. Any read beats already in the CL pipeline still drive.
  - BST stops the burst after the beat in flight.
  - PRECHARGE of the bursting bank stops it immediately.
- A10=1 on READ/WRITE (auto-precharge) closes the bank after the last beat.
- Violations: the first one loads err_code and sets err=1. Both hold until reset.
  - 1: READ/WRITE/ACTIVE before init_ok.
  - 2: READ/WRITE to an idle bank.
  - 3: ACTIVE to an open bank.
  - 4: tRCD violated.
  - 5: tRP violated.
  - 6: tRFC violated.
  - 7: AUTO REFRESH while any bank is open.
  - 8: refresh watchdog expired.
- An offending READ/WRITE is not executed. An offending ACTIVE still opens the bank.

## Timing
- Reset values: dq_out=0, dq_oe=0, init_ok=0, err=0, err_code=0, all banks closed, mode BL=1/CL=3, init FSM in I_WAIT_PRE.
- Reset asserted mid-burst clears dq_oe asynchronously and drops the burst.
- dq_out and dq_oe are registered.
- Write data has zero latency: the beat is sampled on the WRITE edge.
- Read-to-write turnaround: a WRITE during pending read beats cancels those beats; dq_oe goes low at the next edge.
- A READ and a BST on the same edge cannot occur (single command bus); BST with no active burst is a no-op.
- tRCD/tRP/tRFC counters are saturating 4-bit values. Count 0 means the command is on the same edge.

## Configuration
- SDRAM_MODEL_REFWDOG_EN defined: a 16-bit counter resets on each AUTO REFRESH once init_ok=1. If it reaches REF_MAX, error 8 is raised.
- SDRAM_MODEL_REFWDOG_EN undefined: no counter and no code 8. Missing refreshes are never flagged.

## Test plan
- Init: PRE-all, 2×REF spaced by T_RFC, MRS addr=0x032 → init_ok=1 one cycle after the MRS edge, err=0.
- Write then read: ACT bank1 row3; after 2 cycles, WRITE col 8 with BL=4 data A0..A3. READ col 8 with CL=3 → dq_out=A0..A3 at read edge+3..+6, dq_oe high exactly 4 cycles.
- DQM masking: write 0x1234 over stored 0xFFFF with dqm=2'b10 → read returns 0xFF34.
- READ to bank 2 while it is idle → err=1, err_code=2, dq_oe stays 0; a later violation leaves the code at 2.
- ACT then READ after 1 cycle (T_RCD=2) → err_code=4. Separately, REF with bank0 open → err_code=7.
- With SDRAM_MODEL_REFWDOG_EN: no REF for 781 cycles after init → err_code=8. Without it → err stays 0.
